// File: rtl/request_node_pkg.sv
// Types shared by the request node and its flit packer.
`ifndef REQUEST_NODE_DEFINES
`include "define_file.sv"
`endif

package request_node_pkg;

    localparam int         NUM_CN     = 3;
    localparam logic [1:0] TGT_DECERR = 2'd3;

    // Local request fields held for the whole ICN transaction.
    typedef struct packed {
        logic [`ADDR_WIDTH-1:0]  paddr;
        logic [2:0]              pprot;
        logic                    pnse;
        logic                    pwrite;
        logic [`DATA_WIDTH-1:0]  pwdata;
        logic [`STRB_WIDTH-1:0]  pstrb;
        logic                    pwakeup;
    } req_fields_t;

    function automatic logic [1:0] decode_tgt(input logic [`ADDR_WIDTH-1:0] addr);
        return addr[`ADDR_WIDTH-1 -: 2];
    endfunction

endpackage

// File: rtl/define_file.sv
// Shared widths and flit field offsets for the RN/CN interconnect.
// Request flit, MSB first: {paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb, pwakeup}.
`ifndef REQUEST_NODE_DEFINES
`define REQUEST_NODE_DEFINES
`define ADDR_WIDTH      32
`define DATA_WIDTH      32
`define STRB_WIDTH      (`DATA_WIDTH/8)
`define REQ_FLIT_WIDTH  (`ADDR_WIDTH+`DATA_WIDTH+`DATA_WIDTH/8+8)
`define RSP_FLIT_WIDTH  (`DATA_WIDTH+2)
`define PWAKEUP_BIT     0
`define PSTRB_LSB       1
`define PWDATA_LSB      (1+`STRB_WIDTH)
`define PWRITE_BIT      (`PWDATA_LSB+`DATA_WIDTH)
`define PENABLE_BIT     (`PWRITE_BIT+1)
`define PSEL_BIT        (`PWRITE_BIT+2)
`define PNSE_BIT        (`PSEL_BIT+1)
`define PPROT_LSB       (`PSEL_BIT+2)
`define PADDR_LSB       (`PSEL_BIT+5)
`define PSLVERR_BIT     0
`define PRDATA_LSB      1
`define PREADY_BIT      (`DATA_WIDTH+1)
`endif

// File: rtl/request_node_flit_pack.sv
// Combinational packer: request fields plus psel/penable into a request flit,
// and a response flit back into pready/prdata/pslverr.
`ifndef REQUEST_NODE_DEFINES
`include "define_file.sv"
`endif

module rn_flit_pack
    import request_node_pkg::*;
(
    input  req_fields_t                 fields_i,
    input  logic                        psel_i,
    input  logic                        penable_i,
    output logic [`REQ_FLIT_WIDTH-1:0]  req_flit_o,
    input  logic [`RSP_FLIT_WIDTH-1:0]  rsp_flit_i,
    output logic                        pready_o,
    output logic [`DATA_WIDTH-1:0]      prdata_o,
    output logic                        pslverr_o
);

    always_comb begin
        req_flit_o                                  = '0;
        req_flit_o[`PADDR_LSB +: `ADDR_WIDTH]       = fields_i.paddr;
        req_flit_o[`PPROT_LSB +: 3]                 = fields_i.pprot;
        req_flit_o[`PNSE_BIT]                       = fields_i.pnse;
        req_flit_o[`PSEL_BIT]                       = psel_i;
        req_flit_o[`PENABLE_BIT]                    = penable_i;
        req_flit_o[`PWRITE_BIT]                     = fields_i.pwrite;
        req_flit_o[`PWDATA_LSB +: `DATA_WIDTH]      = fields_i.pwdata;
        req_flit_o[`PSTRB_LSB +: `STRB_WIDTH]       = fields_i.pstrb;
        req_flit_o[`PWAKEUP_BIT]                    = fields_i.pwakeup;
    end

    assign pready_o  = rsp_flit_i[`PREADY_BIT];
    assign prdata_o  = rsp_flit_i[`PRDATA_LSB +: `DATA_WIDTH];
    assign pslverr_o = rsp_flit_i[`PSLVERR_BIT];

endmodule

// File: rtl/request_node.sv
// APB completer that forwards each local transfer as a request flit to one of
// three complete nodes and returns that node's response on the local bus.
`ifndef REQUEST_NODE_DEFINES
`include "define_file.sv"
`endif

module request_node
    import request_node_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic [`ADDR_WIDTH-1:0]      s_paddr,
    input  logic [2:0]                  s_pprot,
    input  logic                        s_pnse,
    input  logic                        s_psel,
    input  logic                        s_penable,
    input  logic                        s_pwrite,
    input  logic                        s_pwakeup,
    input  logic [`DATA_WIDTH-1:0]      s_pwdata,
    input  logic [`STRB_WIDTH-1:0]      s_pstrb,
    output logic                        s_pready,
    output logic [`DATA_WIDTH-1:0]      s_prdata,
    output logic                        s_pslverr,
    output logic [NUM_CN-1:0]           rn_valid,
    input  logic [NUM_CN-1:0]           cn_ready,
    output logic [`REQ_FLIT_WIDTH-1:0]  icn_txreq_1,
    output logic [`REQ_FLIT_WIDTH-1:0]  icn_txreq_2,
    output logic [`REQ_FLIT_WIDTH-1:0]  icn_txreq_3,
    input  logic [`RSP_FLIT_WIDTH-1:0]  icn_rxrsp_1,
    input  logic [`RSP_FLIT_WIDTH-1:0]  icn_rxrsp_2,
    input  logic [`RSP_FLIT_WIDTH-1:0]  icn_rxrsp_3,
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_SETUP, S_ACCESS, S_RESP} state_t;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    state_t                      state_q, state_d;
    req_fields_t                 fields_q, fields_d;
    logic [1:0]                  tgt_q, tgt_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_CN-1:0]           rn_valid_q, rn_valid_d;
    logic [`REQ_FLIT_WIDTH-1:0]  txreq_q [NUM_CN];
    logic [`REQ_FLIT_WIDTH-1:0]  txreq_d [NUM_CN];
    logic                        s_pready_q, s_pready_d;
    logic [`DATA_WIDTH-1:0]      s_prdata_q, s_prdata_d;
    logic                        s_pslverr_q, s_pslverr_d;

    logic                        grant;
    logic [`RSP_FLIT_WIDTH-1:0]  rsp_sel;
    logic                        rsp_pready, rsp_pslverr;
    logic [`DATA_WIDTH-1:0]      rsp_prdata;
    logic [`REQ_FLIT_WIDTH-1:0]  req_flit;
    logic                        flit_active, flit_psel, flit_penable;
    logic                        timeout_hit;
    logic                        unused_penable;

    // The local penable carries no information here: the ICN phases are
    // generated by the FSM, not copied from the local bus.
    assign unused_penable = s_penable;

    always_comb begin
        grant   = 1'b0;
        rsp_sel = '0;
        case (tgt_q)
            2'd0:    begin grant = cn_ready[0]; rsp_sel = icn_rxrsp_1; end
            2'd1:    begin grant = cn_ready[1]; rsp_sel = icn_rxrsp_2; end
            2'd2:    begin grant = cn_ready[2]; rsp_sel = icn_rxrsp_3; end
            default: begin grant = 1'b0;        rsp_sel = '0;          end
        endcase
    end

    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        fields_d    = fields_q;
        tgt_d       = tgt_q;
        cnt_d       = '0;
        s_pready_d  = 1'b0;
        s_prdata_d  = '0;
        s_pslverr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (s_psel) begin
                    fields_d = '{paddr: s_paddr, pprot: s_pprot, pnse: s_pnse,
                                 pwrite: s_pwrite, pwdata: s_pwdata,
                                 pstrb: s_pstrb, pwakeup: s_pwakeup};
                    tgt_d    = decode_tgt(s_paddr);
                    if (decode_tgt(s_paddr) == TGT_DECERR) begin
                        state_d     = S_RESP;
                        s_pready_d  = 1'b1;
                        s_pslverr_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ, S_SETUP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout_hit) begin
                    state_d     = S_RESP;
                    s_pready_d  = 1'b1;
                    s_pslverr_d = 1'b1;
                end else if (state_q == S_SETUP) begin
                    state_d = S_ACCESS;
                end else if (grant) begin
                    state_d = S_SETUP;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the timeout cycle still counts as a normal completion.
                if (rsp_pready) begin
                    state_d     = S_RESP;
                    s_pready_d  = 1'b1;
                    s_prdata_d  = rsp_prdata;
                    s_pslverr_d = rsp_pslverr;
                end else if (timeout_hit) begin
                    state_d     = S_RESP;
                    s_pready_d  = 1'b1;
                    s_pslverr_d = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        flit_active  = (state_d == S_REQ) || (state_d == S_SETUP) || (state_d == S_ACCESS);
        flit_psel    = (state_d == S_SETUP) || (state_d == S_ACCESS);
        flit_penable = (state_d == S_ACCESS);
        for (int i = 0; i < NUM_CN; i++) begin
            rn_valid_d[i] = flit_active && (tgt_d == 2'(i));
            txreq_d[i]    = (flit_active && (tgt_d == 2'(i))) ? req_flit : '0;
        end
    end

    rn_flit_pack u_flit_pack (
        .fields_i   (fields_d),
        .psel_i     (flit_psel),
        .penable_i  (flit_penable),
        .req_flit_o (req_flit),
        .rsp_flit_i (rsp_sel),
        .pready_o   (rsp_pready),
        .prdata_o   (rsp_prdata),
        .pslverr_o  (rsp_pslverr)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= S_IDLE;
            fields_q    <= '0;
            tgt_q       <= '0;
            cnt_q       <= '0;
            rn_valid_q  <= '0;
            s_pready_q  <= 1'b0;
            s_prdata_q  <= '0;
            s_pslverr_q <= 1'b0;
            for (int i = 0; i < NUM_CN; i++) txreq_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            fields_q    <= fields_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            rn_valid_q  <= rn_valid_d;
            s_pready_q  <= s_pready_d;
            s_prdata_q  <= s_prdata_d;
            s_pslverr_q <= s_pslverr_d;
            for (int i = 0; i < NUM_CN; i++) txreq_q[i] <= txreq_d[i];
        end
    end

    assign s_pready    = s_pready_q;
    assign s_prdata    = s_prdata_q;
    assign s_pslverr   = s_pslverr_q;
    assign rn_valid    = rn_valid_q;
    assign icn_txreq_1 = txreq_q[0];
    assign icn_txreq_2 = txreq_q[1];
    assign icn_txreq_3 = txreq_q[2];
    assign dbg_state   = state_q;

endmodule

// File: doc/request_node.md
# request_node

Requester-side endpoint of the RN–CN interconnect: an APB completer facing one local APB requester that turns each local transfer into an ICN request flit for one of three complete nodes. It performs the rn_valid/cn_ready handshake and sequences the APB setup and access phases inside the flit. It returns the selected node's response to the local bus. It is the counterpart of the complete node, which arbitrates rn_valid and replays flits onto its APB bus.

## Interface
- ADDR_WIDTH, `ADDR_WIDTH, local/flit address width
- DATA_WIDTH, `DATA_WIDTH, data width (multiple of 8)
- REQ_FLIT_WIDTH, `REQ_FLIT_WIDTH, = ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8+8
- RSP_FLIT_WIDTH, `RSP_FLIT_WIDTH, = DATA_WIDTH+2
- TIMEOUT_CYCLES, 256, max cycles from leaving IDLE to response before forced error (≥4)
- pclk  in  1  clock
- preset  in  1  asynchronous, active-high reset
- s_paddr  in  ADDR_WIDTH  local APB address
- s_pprot  in  3  local protection
- s_pnse, s_psel, s_penable, s_pwrite, s_pwakeup  in  1 each  local APB control
- s_pwdata  in  DATA_WIDTH  write data
- s_pstrb  in  DATA_WIDTH/8  write strobes
- s_pready  out  1  local ready
- s_prdata  out  DATA_WIDTH  local read data
- s_pslverr  out  1  local error
- rn_valid  out  3  per-CN request (bit i → CN i+1)
- cn_ready  in  3  per-CN grant
- icn_txreq_1..3  out  REQ_FLIT_WIDTH each  flit {paddr,pprot,pnse,psel,penable,pwrite,pwdata,pstrb,pwakeup}, MSB first
- icn_rxrsp_1..3  in  RSP_FLIT_WIDTH each  flit {pready,prdata,pslverr}, MSB first

## Operation
- All outputs registered; reset value 0 on every output, state IDLE, timeout counter 0.
- Decode: tgt = s_paddr[ADDR_WIDTH-1:ADDR_WIDTH-2]; 0/1/2 → CN1/CN2/CN3; 3 → decode error, no ICN activity.
- FSM states: IDLE, REQ, SETUP, ACCESS, RESP.
- IDLE: on s_psel=1 capture all local request fields and tgt. tgt=3 → RESP with err=1, rdata=0. Otherwise → REQ.
- REQ: rn_valid[tgt]=1. cn_ready[tgt]=1 sampled → SETUP. cn_ready of other nodes ignored.
- SETUP (1 cycle): icn_txreq_tgt = captured fields with psel=1, penable=0. rn_valid[tgt] stays 1.
- ACCESS: same flit with penable=1. When rsp pready=1 from icn_rxrsp_tgt, capture prdata/pslverr → RESP. Unselected rsp flits are ignored.
- RESP (1 cycle): rn_valid=0, all txreq flits 0. s_pready=1, s_prdata/s_pslverr = captured values → IDLE.
- Unselected txreq flits are always 0. In IDLE/REQ/RESP the selected flit's psel and penable are 0.
- Timeout: counter runs in REQ/SETUP/ACCESS. Reaching TIMEOUT_CYCLES-1 → RESP with err=1, rdata=0. A pready arriving in the same cycle wins and yields a normal response.
- Local requester dropping s_psel mid-transaction: ignored. The ICN transaction completes and RESP still pulses s_pready.
- New local transfer is accepted only from IDLE. Back-to-back transfers have the IDLE cycle between them.
- Async reset mid-transaction: immediate return to IDLE with all outputs 0. rn_valid drops, and the CN sees psel fall.

## Timing
- Cycle 0 IDLE samples s_psel. Cycle 1 REQ with rn_valid=1; cn_ready seen here gives cycle 2 SETUP, cycle 3 ACCESS. pready=1 seen at cycle 3 gives s_pready=1 at cycle 4.
- Minimum local latency is 4 cycles (s_psel sample to s_pready). Each extra cn_ready wait cycle or pready-low cycle adds 1.
- Decode error: s_pready=1 at cycle 1.
- s_pready is high for exactly one cycle per transfer.

## Structure
- Shared (define_file.sv): ADDR_WIDTH, DATA_WIDTH, REQ/RSP_FLIT_WIDTH, PSEL_BIT, and the flit field offset macros (PENABLE_BIT, PWRITE_BIT, PADDR_LSB, PREADY_BIT, PRDATA_LSB).
- FSM state encoding is local to the block.
- One sub-module: rn_flit_pack, combinational. It packs the captured fields plus psel/penable into a flit and unpacks a response flit into pready/prdata/pslverr.

## Test plan
- Write, s_paddr=0x0000_0010 (tgt 0), pwdata=0xA5A5_5A5A, cn_ready[0] immediate, pready at first ACCESS → rn_valid=3'b001; flit psel/penable 1/0 then 1/1; s_pready at cycle 4, s_pslverr=0; txreq_2/3 stay 0.
- Read from tgt 2, cn_ready delayed 3 cycles, pready delayed 2 cycles, prdata=0xDEAD_BEEF, pslverr=1 → s_pready at cycle 9, s_prdata=0xDEAD_BEEF, s_pslverr=1.
- Address with top bits 2'b11 → no rn_valid; s_pready=1, s_pslverr=1, s_prdata=0 at cycle 1.
- TIMEOUT_CYCLES=8, cn_ready never asserted → s_pslverr=1 pulse 8 cycles after IDLE exit; rn_valid back to 0.
- preset asserted during ACCESS → same-cycle async clear of rn_valid, flits and s_pready; next s_psel starts a clean transfer.
- Stray pready on icn_rxrsp_2 while targeting CN1 → ignored; completion only on CN1 response.
